// File: rtl/usb_key_loader.sv
// Assembles sixteen received key bytes into a 128-bit key, strobing each completed 32-bit word.
// Optional trailing XOR checksum byte enabled by USB_KEY_LOADER_CHECKSUM_EN.
module usb_key_loader #(
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         start_i,
    input  logic [7:0]   rx_data_i,
    input  logic         rx_valid_i,
    output logic         rx_ready_o,
    output logic         word_strobe_o,
    output logic [1:0]   word_index_o,
    output logic [31:0]  key_word_o,
    output logic [127:0] key_out_o,
    output logic         key_ready_o,
    output logic         key_error_o,
    output logic         busy_o
);

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned KEY_W  = 128;
    localparam int unsigned CNT_W  = 4;

`ifdef USB_KEY_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DONE, S_ERROR, S_CHECK} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DONE, S_ERROR} state_t;
`endif

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [WORD_W-1:0]   asm_q, asm_d;
    logic [KEY_W-1:0]    key_q, key_d;
    logic [WORD_W-1:0]   kword_q, kword_d;
    logic [1:0]          widx_q, widx_d;
    logic                strobe_q, strobe_d;
    logic                ready_q, ready_d;
    logic                active_q, active_d;
    logic                xfer_c;
    logic [WORD_W-1:0]   shifted_c;
`ifdef USB_KEY_LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0]   xor_q, xor_d;
    logic                err_q, err_d;
`endif

    // active_q mirrors "state is LOAD or CHECK", so rx_ready is a pure state decode
    assign xfer_c    = rx_valid_i && active_q;
    assign shifted_c = MSB_FIRST ? {asm_q[WORD_W-BYTE_W-1:0], rx_data_i}
                                 : {rx_data_i, asm_q[WORD_W-1:BYTE_W]};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        asm_d    = asm_q;
        key_d    = key_q;
        kword_d  = kword_q;
        widx_d   = widx_q;
        strobe_d = 1'b0;
        ready_d  = ready_q;
`ifdef USB_KEY_LOADER_CHECKSUM_EN
        xor_d    = xor_q;
        err_d    = err_q;
`endif
        if (start_i) begin
            // restart from any state; a byte presented alongside start is dropped
            state_d = S_LOAD;
            cnt_d   = '0;
            asm_d   = '0;
            key_d   = '0;
            ready_d = 1'b0;
`ifdef USB_KEY_LOADER_CHECKSUM_EN
            xor_d   = '0;
            err_d   = 1'b0;
`endif
        end else begin
            case (state_q)
                S_LOAD: begin
                    if (xfer_c) begin
                        asm_d = shifted_c;
`ifdef USB_KEY_LOADER_CHECKSUM_EN
                        xor_d = xor_q ^ rx_data_i;
`endif
                        if (cnt_q[1:0] == 2'd3) begin
                            strobe_d = 1'b1;
                            widx_d   = cnt_q[3:2];
                            kword_d  = shifted_c;
                            case (cnt_q[3:2])
                                2'd0:    key_d[127:96] = shifted_c;
                                2'd1:    key_d[95:64]  = shifted_c;
                                2'd2:    key_d[63:32]  = shifted_c;
                                default: key_d[31:0]   = shifted_c;
                            endcase
                        end
                        if (cnt_q == CNT_W'(15)) begin
`ifdef USB_KEY_LOADER_CHECKSUM_EN
                            state_d = S_CHECK;
`else
                            state_d = S_DONE;
                            ready_d = 1'b1;
`endif
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
`ifdef USB_KEY_LOADER_CHECKSUM_EN
                S_CHECK: begin
                    if (xfer_c) begin
                        if (rx_data_i == xor_q) begin
                            state_d = S_DONE;
                            ready_d = 1'b1;
                        end else begin
                            state_d = S_ERROR;
                            err_d   = 1'b1;
                            key_d   = '0;
                        end
                    end
                end
`endif
                default: ;
            endcase
        end
`ifdef USB_KEY_LOADER_CHECKSUM_EN
        active_d = (state_d == S_LOAD) || (state_d == S_CHECK);
`else
        active_d = (state_d == S_LOAD);
`endif
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            asm_q    <= '0;
            key_q    <= '0;
            kword_q  <= '0;
            widx_q   <= '0;
            strobe_q <= 1'b0;
            ready_q  <= 1'b0;
            active_q <= 1'b0;
`ifdef USB_KEY_LOADER_CHECKSUM_EN
            xor_q    <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            asm_q    <= asm_d;
            key_q    <= key_d;
            kword_q  <= kword_d;
            widx_q   <= widx_d;
            strobe_q <= strobe_d;
            ready_q  <= ready_d;
            active_q <= active_d;
`ifdef USB_KEY_LOADER_CHECKSUM_EN
            xor_q    <= xor_d;
            err_q    <= err_d;
`endif
        end
    end

    assign rx_ready_o    = active_q;
    assign busy_o        = active_q;
    assign word_strobe_o = strobe_q;
    assign word_index_o  = widx_q;
    assign key_word_o    = kword_q;
    assign key_out_o     = key_q;
    assign key_ready_o   = ready_q;
`ifdef USB_KEY_LOADER_CHECKSUM_EN
    assign key_error_o   = err_q;
`else
    assign key_error_o   = 1'b0;
`endif

endmodule

// File: tb/tb_usb_key_loader.sv
// Bench for usb_key_loader: MSB-first and LSB-first instances checked each cycle against a byte-list model.
module tb_usb_key_loader;

    logic         clk = 1'b0;
    logic         n_rst = 1'b0;
    logic         start = 1'b0;
    logic         rx_valid = 1'b0;
    logic [7:0]   rx_data = 8'h00;

    logic         rdy1, stb1, krdy1, kerr1, busy1;
    logic [1:0]   wi1;
    logic [31:0]  kw1;
    logic [127:0] ko1;
    logic         rdy0, stb0, krdy0, kerr0, busy0;
    logic [1:0]   wi0;
    logic [31:0]  kw0;
    logic [127:0] ko0;

    int checks = 0;
    int errors = 0;

    usb_key_loader #(.MSB_FIRST(1'b1)) dut1 (
        .clk(clk), .n_rst(n_rst), .start_i(start), .rx_data_i(rx_data), .rx_valid_i(rx_valid),
        .rx_ready_o(rdy1), .word_strobe_o(stb1), .word_index_o(wi1), .key_word_o(kw1),
        .key_out_o(ko1), .key_ready_o(krdy1), .key_error_o(kerr1), .busy_o(busy1)
    );

    usb_key_loader #(.MSB_FIRST(1'b0)) dut0 (
        .clk(clk), .n_rst(n_rst), .start_i(start), .rx_data_i(rx_data), .rx_valid_i(rx_valid),
        .rx_ready_o(rdy0), .word_strobe_o(stb0), .word_index_o(wi0), .key_word_o(kw0),
        .key_out_o(ko0), .key_ready_o(krdy0), .key_error_o(kerr0), .busy_o(busy0)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    // Model: list of accepted bytes since the last start, plus outcome flags
    bit          m_act = 1'b0;
    int          m_n = 0;
    logic [7:0]  m_b [16];
    logic [7:0]  m_x = 8'h00;
    bit          m_rdy = 1'b0;
    bit          m_err = 1'b0;
    bit          m_stb = 1'b0;
    logic [1:0]  m_wi = 2'd0;
    logic [31:0] m_kw1 = 32'h0;
    logic [31:0] m_kw0 = 32'h0;

    function automatic logic [31:0] mword(input int w, input bit msb);
        logic [7:0] a, b, c, d;
        a = m_b[4*w]; b = m_b[4*w+1]; c = m_b[4*w+2]; d = m_b[4*w+3];
        return msb ? {a, b, c, d} : {d, c, b, a};
    endfunction

    function automatic logic [127:0] mkey(input bit msb);
        logic [127:0] k;
        k = '0;
        if (!m_err)
            for (int w = 0; w < 4; w++)
                if (m_n >= 4*w + 4) k[127-32*w -: 32] = mword(w, msb);
        return k;
    endfunction

    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            m_act = 1'b0; m_n = 0; m_x = 8'h00; m_rdy = 1'b0; m_err = 1'b0;
            m_stb = 1'b0; m_wi = 2'd0; m_kw1 = 32'h0; m_kw0 = 32'h0;
        end else begin
            m_stb = 1'b0;
            if (start) begin
                m_act = 1'b1; m_n = 0; m_x = 8'h00; m_rdy = 1'b0; m_err = 1'b0;
            end else if (m_act && rx_valid) begin
                if (m_n < 16) begin
                    m_b[m_n] = rx_data;
                    m_x = m_x ^ rx_data;
                    m_n++;
                    if (m_n % 4 == 0) begin
                        m_stb = 1'b1;
                        m_wi  = 2'(m_n / 4 - 1);
                        m_kw1 = mword(m_n / 4 - 1, 1'b1);
                        m_kw0 = mword(m_n / 4 - 1, 1'b0);
                    end
`ifndef USB_KEY_LOADER_CHECKSUM_EN
                    if (m_n == 16) begin m_act = 1'b0; m_rdy = 1'b1; end
`endif
                end else begin
                    m_act = 1'b0;
                    if (rx_data == m_x) m_rdy = 1'b1;
                    else m_err = 1'b1;
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    logic [31:0] sq[$];
    logic [1:0]  iq[$];
    always @(negedge clk) begin
        chk("rx_ready", 128'(rdy1), 128'(m_act));
        chk("busy", 128'(busy1), 128'(m_act));
        chk("rx_ready_lsb", 128'(rdy0), 128'(m_act));
        chk("word_strobe", 128'(stb1), 128'(m_stb));
        chk("key_ready", 128'(krdy1), 128'(m_rdy));
        chk("key_error", 128'(kerr1), 128'(m_err));
        chk("key_out_msb", ko1, mkey(1'b1));
        chk("key_out_lsb", ko0, mkey(1'b0));
        chk("ready_err_excl", 128'(krdy1 && kerr1), 128'(0));
        if (m_stb) begin
            chk("key_word_msb", 128'(kw1), 128'(m_kw1));
            chk("key_word_lsb", 128'(kw0), 128'(m_kw0));
            chk("word_index", 128'(wi1), 128'(m_wi));
        end
        if (stb1) begin sq.push_back(kw1); iq.push_back(wi1); end
    end

    task automatic step(input logic s, input logic v, input logic [7:0] d);
        start = s; rx_valid = v; rx_data = d;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [127:0] exp_key;
        logic [7:0]   b;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_key_out", ko1, 128'h0);
        chk("reset_rx_ready", 128'(rdy1), 128'h0);
        n_rst = 1'b1;
        @(posedge clk); #1;

        // Sequential bytes 0x00..0x0F
        sq.delete(); iq.delete();
        step(1'b1, 1'b1, 8'h55);
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 8'(i));
`ifdef USB_KEY_LOADER_CHECKSUM_EN
        step(1'b0, 1'b1, 8'h00);
`endif
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        exp_key = 128'h000102030405060708090A0B0C0D0E0F;
        chk("model_pin_key", mkey(1'b1), exp_key);
        chk("seq_key_out", ko1, exp_key);
        chk("seq_lsb_word0", 128'(ko0[127:96]), 128'h03020100);
        chk("seq_key_ready", 128'(krdy1), 128'h1);
        chk("seq_strobes", 128'(sq.size()), 128'd4);
        if (sq.size() == 4) begin
            chk("seq_word0", 128'(sq[0]), 128'h00010203);
            chk("seq_word1", 128'(sq[1]), 128'h04050607);
            chk("seq_word2", 128'(sq[2]), 128'h08090A0B);
            chk("seq_word3", 128'(sq[3]), 128'h0C0D0E0F);
            chk("seq_idx3", 128'(iq[3]), 128'd3);
            chk("seq_idx0", 128'(iq[0]), 128'd0);
        end

        // rx_valid toggling 1,0 over 8 bytes
        sq.delete();
        step(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 8'(8'h10 + i));
            chk("toggle_rx_ready_a", 128'(rdy1), 128'h1);
            step(1'b0, 1'b0, 8'hEE);
            chk("toggle_rx_ready_b", 128'(rdy1), 128'h1);
        end
        chk("toggle_strobes", 128'(sq.size()), 128'd2);
        chk("toggle_key_hi", 128'(ko1[127:64]), 128'h1011121314151617);

        // Restart mid-load, then all 0xFF
        step(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 8'($urandom_range(0, 254)));
        step(1'b1, 1'b1, 8'hAA);
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 8'hFF);
`ifdef USB_KEY_LOADER_CHECKSUM_EN
        step(1'b0, 1'b1, 8'h00);
`endif
        step(1'b0, 1'b0, 8'h00);
        chk("restart_key_msb", ko1, {128{1'b1}});
        chk("restart_key_lsb", ko0, {128{1'b1}});
        chk("restart_ready", 128'(krdy1), 128'h1);

`ifdef USB_KEY_LOADER_CHECKSUM_EN
        // Bad checksum
        step(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 8'(i));
        step(1'b0, 1'b1, 8'h01);
        step(1'b0, 1'b0, 8'h00);
        chk("bad_ck_error", 128'(kerr1), 128'h1);
        chk("bad_ck_ready", 128'(krdy1), 128'h0);
        chk("bad_ck_key", ko1, 128'h0);
`endif

        // Asynchronous reset after 10 bytes
        step(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 8'(8'h30 + i));
        #2 n_rst = 1'b0;
        #1;
        chk("async_rx_ready", 128'(rdy1), 128'h0);
        chk("async_busy", 128'(busy1), 128'h0);
        chk("async_key_out", ko1, 128'h0);
        chk("async_key_word", 128'(kw1), 128'h0);
        chk("async_word_index", 128'(wi1), 128'h0);
        #1 n_rst = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 8'h77);
            chk("post_reset_rx_ready", 128'(rdy1), 128'h0);
        end

        // Randomized traffic with occasional restarts
        for (int i = 0; i < 1500; i++) begin
            b = 8'($urandom_range(0, 255));
            if (m_n == 16 && $urandom_range(0, 1) == 1) b = m_x;
            step(1'(($urandom_range(0, 39) == 0) || (!m_act && $urandom_range(0, 7) == 0)),
                 1'($urandom_range(0, 3) != 0), b);
        end

        step(1'b0, 1'b0, 8'h00);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
